memory_bi_burst: RTL and testbench

- Parametrised single-port synchronous RAM on a shared bidirectional data bus; next generation of the 32x8 bidirectional memory.
- Adds configurable width/depth, synchronous reset, multi-beat bursts with an internal auto-incrementing address, a write stall handshake, mid-burst abort and explicit busy/valid status.
- Sits on the processor's data bus as instruction/data store.

---
 rtl/memory_bi_burst.sv | 120 ++++++++++++
 tb/tb_memory_bi_burst.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bi_burst.sv
// Parametrised single-port RAM on a bidirectional data bus.
// Supports multi-beat bursts, write stall, abort and busy/valid status.
module memory_bi_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int BURST_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BURST_W-1:0]    burst_len,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  busy,
    output logic                  valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [BURST_W-1:0]    r_beats_left;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_step;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_mem_addr;

    assign w_last = (r_beats_left == BURST_W'(1));

    // Next-state and per-edge memory/counter strobes
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_step     = 1'b0;
        w_wr       = 1'b0;
        w_rd       = 1'b0;
        w_mem_addr = r_addr_cnt;
        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_accept   = 1'b1;
                    w_mem_addr = addr;
                    w_wr       = rw;
                    w_rd       = !rw;
                    if (burst_len != '0)
                        w_next = rw ? WBURST : RBURST;
                end
            end
            WBURST: begin
                if (!en) begin
                    w_next = IDLE;
                end else if (rw) begin
                    w_wr   = 1'b1;
                    w_step = 1'b1;
                    if (w_last)
                        w_next = IDLE;
                end
            end
            RBURST: begin
                if (!en) begin
                    w_next = IDLE;
                end else begin
                    w_rd   = 1'b1;
                    w_step = 1'b1;
                    if (w_last)
                        w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State, burst counters and read data register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr_cnt   <= '0;
            r_beats_left <= '0;
            r_dout       <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_rd;
            if (w_accept) begin
                r_addr_cnt   <= addr + ADDR_WIDTH'(1);
                r_beats_left <= burst_len;
            end else if (w_step) begin
                r_addr_cnt   <= r_addr_cnt + ADDR_WIDTH'(1);
                r_beats_left <= r_beats_left - BURST_W'(1);
            end
            if (w_rd)
                r_dout <= r_mem[w_mem_addr];
        end
    end

    // RAM array write port; contents survive reset, reset edge blocks writes
    always_ff @(posedge clk) begin
        if (!rst && w_wr)
            r_mem[w_mem_addr] <= data;
    end

    assign data  = r_valid ? r_dout : {DATA_WIDTH{1'bz}};
    assign busy  = (r_state != IDLE);
    assign valid = r_valid;

endmodule

// File: tb/tb_memory_bi_burst.sv
// Self-checking bench for memory_bi_burst.
// Directed scenarios plus randomized bursts against an array model.
module tb_memory_bi_burst;

    logic       clk;
    logic       rst;
    logic       en;
    logic       rw;
    logic [4:0] addr;
    logic [2:0] bl;
    logic       drv;
    logic [7:0] dval;
    wire  [7:0] data;
    logic       busy;
    logic       valid;

    int n_cmp;
    int n_err;
    logic [7:0] ref_mem [32];
    logic [7:0] wbuf [8];

    assign data = drv ? dval : 8'bz;

    memory_bi_burst #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .BURST_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .rw(rw),
        .addr(addr),
        .burst_len(bl),
        .data(data),
        .busy(busy),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en  = 1'b0;
        rw  = 1'b0;
        drv = 1'b0;
        step();
    endtask

    // Driver only: n-beat write burst from wbuf, updates the model
    task automatic wr_burst(input logic [4:0] a, input int n);
        logic [4:0] ai;
        en   = 1'b1;
        rw   = 1'b1;
        drv  = 1'b1;
        addr = a;
        bl   = 3'(n - 1);
        for (int i = 0; i < n; i++) begin
            dval = wbuf[i];
            step();
            ai = a + 5'(i);
            ref_mem[ai] = wbuf[i];
        end
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state busy=%b valid=%b want 0 0", busy, valid);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_single();
        en = 1'b1; rw = 1'b1; drv = 1'b1;
        addr = 5'd1; bl = 3'd0; dval = 8'h02;
        step();
        ref_mem[1] = 8'h02;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_wr_busy got %b want 0", busy);
        end
        rw = 1'b0; drv = 1'b0;
        step();
        n_cmp++;
        if (valid !== 1'b1 || data !== 8'h02 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_rd v=%b d=%h b=%b want 1 02 0",
                     valid, data, busy);
        end
        idle();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_rd_end valid=%b want 0", valid);
        end
    endtask

    task automatic test_write_burst_wrap();
        logic [7:0] exp [4];
        logic [7:0] e2 [2];
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        e2  = '{8'hA2, 8'hA3};
        for (int i = 0; i < 4; i++) wbuf[i] = exp[i];
        wr_burst(5'd30, 4);
        en = 1'b1; rw = 1'b0; addr = 5'd30; bl = 3'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== exp[i]) begin
                n_err++;
                $display("FAIL wrap_rd beat%0d v=%b d=%h want 1 %h",
                         i, valid, data, exp[i]);
            end
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            en = 1'b1; rw = 1'b0; addr = 5'(i); bl = 3'd0;
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== e2[i]) begin
                n_err++;
                $display("FAIL wrap_single a%0d v=%b d=%h want 1 %h",
                         i, valid, data, e2[i]);
            end
            idle();
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4];
        exp = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        en = 1'b1; rw = 1'b1; drv = 1'b1; addr = 5'd4; bl = 3'd3;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                rw = 1'b0; drv = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    n_cmp++;
                    if (busy !== 1'b1 || valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall%0d busy=%b valid=%b want 1 0",
                                 s, busy, valid);
                    end
                end
                rw = 1'b1; drv = 1'b1;
            end
            dval = exp[i];
            step();
            ref_mem[4 + i] = exp[i];
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_done busy=%b want 0", busy);
        end
        idle();
        en = 1'b1; rw = 1'b0; addr = 5'd4; bl = 3'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== exp[i]) begin
                n_err++;
                $display("FAIL stall_rd beat%0d v=%b d=%h want 1 %h",
                         i, valid, data, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_read_abort();
        en = 1'b1; rw = 1'b0; addr = 5'd4; bl = 3'd3;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== ref_mem[4 + i]) begin
                n_err++;
                $display("FAIL abort_rd beat%0d v=%b d=%h want 1 %h",
                         i, valid, data, ref_mem[4 + i]);
            end
        end
        en = 1'b0;
        step();
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_end valid=%b busy=%b want 0 0", valid, busy);
        end
        en = 1'b1; addr = 5'd6; bl = 3'd0;
        step();
        n_cmp++;
        if (valid !== 1'b1 || data !== 8'hB2) begin
            n_err++;
            $display("FAIL abort_next v=%b d=%h want 1 b2", valid, data);
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] exp [4];
        exp = '{8'hD0, 8'hD1, 8'h77, 8'h88};
        wbuf[0] = 8'h55; wbuf[1] = 8'h66;
        wbuf[2] = 8'h77; wbuf[3] = 8'h88;
        wr_burst(5'd8, 4);
        en = 1'b1; rw = 1'b1; drv = 1'b1; addr = 5'd8; bl = 3'd3;
        dval = 8'hD0; step();
        dval = 8'hD1; step();
        ref_mem[8] = 8'hD0;
        ref_mem[9] = 8'hD1;
        dval = 8'hD2; rst = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid busy=%b valid=%b want 0 0", busy, valid);
        end
        rst = 1'b0;
        idle();
        en = 1'b1; rw = 1'b0; addr = 5'd8; bl = 3'd3;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== exp[i]) begin
                n_err++;
                $display("FAIL rst_mid_rd a%0d v=%b d=%h want 1 %h",
                         8 + i, valid, data, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp = '{ref_mem[30], ref_mem[31], ref_mem[0]};
        en = 1'b1; rw = 1'b0; addr = 5'd30; bl = 3'd1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                addr = 5'd0;
                bl   = 3'd0;
            end
            step();
            n_cmp++;
            if (valid !== 1'b1 || data !== exp[i]) begin
                n_err++;
                $display("FAIL b2b beat%0d v=%b d=%h want 1 %h",
                         i, valid, data, exp[i]);
            end
        end
        idle();
        n_cmp++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end valid=%b want 0", valid);
        end
    endtask

    task automatic test_random();
        logic [4:0] a;
        logic [4:0] ai;
        int n;
        int k;
        int st_at;
        int st_len;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
            wr_burst(5'(b * 8), 8);
        end
        for (int it = 0; it < 60; it++) begin
            a = 5'($urandom);
            n = $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) begin
                st_at  = $urandom_range(1, 8);
                st_len = $urandom_range(1, 2);
                en = 1'b1; rw = 1'b1; drv = 1'b1; addr = a; bl = 3'(n - 1);
                for (int i = 0; i < n; i++) begin
                    if (i == st_at) begin
                        rw = 1'b0; drv = 1'b0;
                        for (int s = 0; s < st_len; s++) begin
                            step();
                            n_cmp++;
                            if (busy !== 1'b1 || valid !== 1'b0) begin
                                n_err++;
                                $display("FAIL rnd_stall it%0d b=%b v=%b",
                                         it, busy, valid);
                            end
                        end
                        rw = 1'b1; drv = 1'b1;
                    end
                    dval = 8'($urandom);
                    step();
                    ai = a + 5'(i);
                    ref_mem[ai] = dval;
                end
                idle();
            end else begin
                k = n;
                if (n > 1 && $urandom_range(0, 3) == 0)
                    k = $urandom_range(1, n - 1);
                en = 1'b1; rw = 1'b0; drv = 1'b0; addr = a; bl = 3'(n - 1);
                for (int i = 0; i < k; i++) begin
                    step();
                    ai = a + 5'(i);
                    n_cmp++;
                    if (valid !== 1'b1 || data !== ref_mem[ai]) begin
                        n_err++;
                        $display("FAIL rnd_rd it%0d a%0d v=%b d=%h want 1 %h",
                                 it, ai, valid, data, ref_mem[ai]);
                    end
                end
                idle();
                n_cmp++;
                if (valid !== 1'b0 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL rnd_rd_end it%0d v=%b b=%b want 0 0",
                             it, valid, busy);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst  = 1'b1;
        en   = 1'b0;
        rw   = 1'b0;
        addr = '0;
        bl   = '0;
        drv  = 1'b0;
        dval = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        test_reset();
        test_single();
        test_write_burst_wrap();
        test_stall();
        test_read_abort();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
